// File: rtl/drum_sequencer.sv
// rtl/drum_sequencer.sv - pattern step sequencer issuing deferred one-shot triggers to drum voices
module drum_sequencer #(
    parameter int NUM_VOICES = 4,
    parameter int NUM_STEPS  = 16,
    parameter int STEP_TICKS = 2000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_tick,
    input  logic                         run,
    input  logic                         pat_we,
    input  logic [$clog2(NUM_STEPS)-1:0] pat_step,
    input  logic [NUM_VOICES-1:0]        pat_data,
    input  logic [NUM_VOICES-1:0]        playing,
    input  logic                         missed_clr,
    output logic [NUM_VOICES-1:0]        trigger,
    output logic [$clog2(NUM_STEPS)-1:0] step,
    output logic                         step_pulse,
    output logic [NUM_VOICES-1:0]        missed
);

    localparam int SW = $clog2(NUM_STEPS);
    localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(STEP_TICKS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [NUM_VOICES-1:0]   pattern [NUM_STEPS];
    logic [TW-1:0]           tick_cnt;
    logic [TW-1:0]           tick_nxt;
    logic [SW-1:0]           step_nxt;
    logic [SW-1:0]           step_inc;
    logic [SW-1:0]           new_step;
    logic                    boundary;
    logic [NUM_VOICES-1:0]   row;
    logic [NUM_VOICES-1:0]   issue;
    logic [NUM_VOICES-1:0]   pending;
    logic [NUM_VOICES-1:0]   pending_nxt;
    logic [NUM_VOICES-1:0]   trigger_nxt;
    logic [NUM_VOICES-1:0]   missed_nxt;
    logic                    step_pulse_nxt;
    logic                    row_ok;

    // Row addresses past the last step are dropped; with a power-of-two
    // step count every address is a real row.
    generate
        if (NUM_STEPS == (1 << SW)) begin : g_full_rows
            assign row_ok = 1'b1;
        end else begin : g_partial_rows
            assign row_ok = (pat_step <= LAST_STEP);
        end
    endgenerate

    assign step_inc = (step == LAST_STEP) ? '0 : step + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: run level alone moves between idle and sequencing.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (run) state_nxt = RUN;
            RUN:  if (!run) state_nxt = IDLE;
        endcase
    end

    // Datapath next values: tick counting, step boundaries, pending/trigger/missed.
    always_comb begin
        tick_nxt       = tick_cnt;
        step_nxt       = step;
        boundary       = 1'b0;
        new_step       = '0;
        issue          = '0;
        step_pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                // Starting the sequencer is itself a boundary into step 0.
                if (run) begin
                    boundary = 1'b1;
                    new_step = '0;
                end
            end
            RUN: begin
                if (run) begin
                    issue = pending & ~playing & ~trigger;
                    if (sample_tick) begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_nxt = '0;
                            boundary = 1'b1;
                            new_step = step_inc;
                        end else begin
                            tick_nxt = tick_cnt + 1'b1;
                        end
                    end
                end else begin
                    tick_nxt = '0;
                    step_nxt = '0;
                end
            end
        endcase

        // The grid register still holds the pre-write row during a same-cycle write.
        row = pattern[new_step];

        if (boundary) begin
            step_nxt       = new_step;
            step_pulse_nxt = 1'b1;
        end

        trigger_nxt = issue;

        // A new hit overrides a same-cycle issue clear; stopping discards everything.
        if (state == RUN && !run) begin
            pending_nxt = '0;
        end else begin
            pending_nxt = (pending & ~issue) | (boundary ? row : '0);
        end

        // Any hit still waiting when the next boundary arrives is reported; set beats clear.
        missed_nxt = (missed & ~{NUM_VOICES{missed_clr}})
                   | (boundary ? (pending & ~issue) : '0);
    end

    // Pattern grid storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                pattern[i] <= '0;
            end
        end else if (pat_we && row_ok) begin
            pattern[pat_step] <= pat_data;
        end
    end

    // Registered outputs and sequencing state.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt   <= '0;
            step       <= '0;
            step_pulse <= 1'b0;
            trigger    <= '0;
            pending    <= '0;
            missed     <= '0;
        end else begin
            tick_cnt   <= tick_nxt;
            step       <= step_nxt;
            step_pulse <= step_pulse_nxt;
            trigger    <= trigger_nxt;
            pending    <= pending_nxt;
            missed     <= missed_nxt;
        end
    end

endmodule
